// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the CPU load/store path and the
// debug/loader port. Every access takes two cycles: ACCESS (memory enabled,
// grant pulse to the winner), then RESP (read data returned to the owner).
// Arbitration runs in IDLE and in RESP, so accesses can run back to back.
// When both ports are eligible, the port that did not win last time wins.
// While dbg_lock is high, the CPU is not eligible.
//
// Ports
//   sysclk, rst                  clock (rising edge), async active-high reset
//   cpu_* / dbg_*  req, we, addr, wdata, be   requester inputs (held to gnt)
//   cpu_* / dbg_*  gnt, rvalid, rdata         grant pulse, read return
//   dbg_lock                     excludes the CPU from arbitration
//   mem_en, mem_we, mem_addr, mem_wdata, mem_be   registered memory controls
//   mem_rdata                    synchronous-read data, one cycle after mem_en
//   conflict_cnt                 saturating count of cycles in which one port
//                                was granted while the other was eligible
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    sysclk,
    input  logic                    rst,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,

    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_be,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,

    input  logic                    dbg_lock,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [CNT_WIDTH-1:0]    conflict_cnt
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t                  state_q, state_d;
    logic                    last_dbg_q, last_dbg_d;   // 1 = dbg won the last arbitration
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
    logic                    cpu_gnt_q, cpu_gnt_d;
    logic                    dbg_gnt_q, dbg_gnt_d;
    logic                    cpu_rvalid_q, cpu_rvalid_d;
    logic                    dbg_rvalid_q, dbg_rvalid_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic cpu_elig;
    logic dbg_elig;
    logic pick_dbg;
    logic conflict;

    assign cpu_elig = cpu_req & ~dbg_lock;
    assign dbg_elig = dbg_req;
    // dbg wins when it is alone, or on a tie when the CPU won last time.
    assign pick_dbg = dbg_elig & (~cpu_elig | ~last_dbg_q);
    // gnt_q is only high in ACCESS, so this counts waiting cycles during grants.
    assign conflict = (cpu_gnt_q & dbg_elig) | (dbg_gnt_q & cpu_elig);

    always_comb begin
        state_d      = state_q;
        last_dbg_d   = last_dbg_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cnt_d        = conflict ? sat_inc(cnt_q) : cnt_q;

        case (state_q)
            ST_ACCESS: begin
                state_d      = ST_RESP;
                // The memory was read at the end of this cycle; the owner
                // sees the data during RESP.
                cpu_rvalid_d = cpu_gnt_q & ~mem_we_q;
                dbg_rvalid_d = dbg_gnt_q & ~mem_we_q;
            end
            default: begin
                // IDLE and RESP both arbitrate; an unused encoding falls here
                // too and recovers.
                if (cpu_elig | dbg_elig) begin
                    state_d    = ST_ACCESS;
                    last_dbg_d = pick_dbg;
                    mem_en_d   = 1'b1;
                    cpu_gnt_d  = ~pick_dbg;
                    dbg_gnt_d  = pick_dbg;
                    if (pick_dbg) begin
                        mem_we_d    = dbg_we;
                        mem_addr_d  = dbg_addr;
                        mem_wdata_d = dbg_wdata;
                        mem_be_d    = dbg_be;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        mem_be_d    = cpu_be;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_dbg_q   <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_dbg_q   <= last_dbg_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign cpu_gnt      = cpu_gnt_q;
    assign dbg_gnt      = dbg_gnt_q;
    assign cpu_rvalid   = cpu_rvalid_q;
    assign dbg_rvalid   = dbg_rvalid_q;
    assign conflict_cnt = cnt_q;

    // Read data is a straight copy of the memory output; qualify with rvalid.
    assign cpu_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int CW = 16;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;

    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [BW-1:0] cpu_be = '0;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [BW-1:0] dbg_be = '0;
    logic          dbg_lock = 1'b0;

    logic          cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] conflict_cnt;

    // Second instance with a 4-bit counter, fed the same stimulus.
    logic          s_cpu_gnt, s_dbg_gnt, s_cpu_rvalid, s_dbg_rvalid;
    logic [DW-1:0] s_cpu_rdata, s_dbg_rdata;
    logic          s_mem_en, s_mem_we;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata;
    logic [BW-1:0] s_mem_be;
    logic [3:0]    s_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .sysclk(sysclk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
        .sysclk(sysclk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
        .dbg_lock(dbg_lock),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_be(s_mem_be), .mem_rdata(mem_rdata), .conflict_cnt(s_cnt)
    );

    // DMEM macro stand-in: synchronous read, byte-enabled write.
    logic [DW-1:0] mem [0:4095] = '{default: '0};
    always @(posedge sysclk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // An access lives for two cycles: a grant cycle (m_cur) and a response
    // cycle (m_rsp). A new winner is chosen only when no access is in its
    // grant cycle.
    logic [DW-1:0] ref_mem [0:4095] = '{default: '0};
    bit            m_cur_v = 0, m_cur_dbg = 0, m_cur_we = 0;
    logic [AW-1:0] m_cur_addr = '0;
    logic [DW-1:0] m_cur_wdata = '0;
    logic [BW-1:0] m_cur_be = '0;
    bit            m_rsp_v = 0, m_rsp_dbg = 0, m_rsp_we = 0;
    logic [DW-1:0] m_rsp_data = '0;
    bit            m_last_dbg = 1;
    int            m_cnt = 0;
    bit            ec, ed, arb_ok, win, exp_crv, exp_drv;

    initial begin
        forever begin
            @(negedge sysclk);
            if (rst) begin
                chk("rst_cpu_gnt", cpu_gnt, 0);
                chk("rst_dbg_gnt", dbg_gnt, 0);
                chk("rst_cpu_rvalid", cpu_rvalid, 0);
                chk("rst_dbg_rvalid", dbg_rvalid, 0);
                chk("rst_mem_en", mem_en, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_be", mem_be, 0);
                chk("rst_conflict_cnt", conflict_cnt, 0);
                chk("rst_sat_cnt", s_cnt, 0);
                m_cur_v = 0; m_rsp_v = 0; m_last_dbg = 1; m_cnt = 0;
            end else begin
                chk("cpu_gnt", cpu_gnt, m_cur_v && !m_cur_dbg);
                chk("dbg_gnt", dbg_gnt, m_cur_v && m_cur_dbg);
                chk("mem_en", mem_en, m_cur_v);
                if (m_cur_v) begin
                    chk("mem_we", mem_we, m_cur_we);
                    chk("mem_addr", mem_addr, m_cur_addr);
                    chk("mem_wdata", mem_wdata, m_cur_wdata);
                    chk("mem_be", mem_be, m_cur_be);
                end
                exp_crv = m_rsp_v && !m_rsp_we && !m_rsp_dbg;
                exp_drv = m_rsp_v && !m_rsp_we && m_rsp_dbg;
                chk("cpu_rvalid", cpu_rvalid, exp_crv);
                chk("dbg_rvalid", dbg_rvalid, exp_drv);
                if (exp_crv) chk("cpu_rdata", cpu_rdata, m_rsp_data);
                if (exp_drv) chk("dbg_rdata", dbg_rdata, m_rsp_data);
                chk("conflict_cnt", conflict_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
                chk("sat_cnt", s_cnt, (m_cnt > 15) ? 15 : m_cnt);

                // advance by one cycle using this cycle's inputs
                ec = cpu_req && !dbg_lock;
                ed = dbg_req;
                arb_ok = !m_cur_v;
                if (m_cur_v && (m_cur_dbg ? ec : ed)) m_cnt++;
                m_rsp_v = m_cur_v; m_rsp_dbg = m_cur_dbg; m_rsp_we = m_cur_we;
                if (m_cur_v) begin
                    m_rsp_data = ref_mem[m_cur_addr];
                    if (m_cur_we)
                        for (int b = 0; b < BW; b++)
                            if (m_cur_be[b]) ref_mem[m_cur_addr][8*b +: 8] = m_cur_wdata[8*b +: 8];
                end
                m_cur_v = 0;
                if (arb_ok && (ec || ed)) begin
                    win = (ec && ed) ? !m_last_dbg : ed;
                    m_last_dbg  = win;
                    m_cur_v     = 1;
                    m_cur_dbg   = win;
                    m_cur_we    = win ? dbg_we : cpu_we;
                    m_cur_addr  = win ? dbg_addr : cpu_addr;
                    m_cur_wdata = win ? dbg_wdata : cpu_wdata;
                    m_cur_be    = win ? dbg_be : cpu_be;
                end
            end
        end
    end

    // Each port drops its request in the cycle after its own grant.
    task automatic drain();
        bit pc, pd;
        for (int t = 0; t < 8; t++) begin
            pc = cpu_gnt; pd = dbg_gnt;
            tick();
            if (pc) cpu_req = 1'b0;
            if (pd) dbg_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit got, pc, pd;

        // reset state
        tick(); tick();
        chk("reset_mem_en", mem_en, 0);
        chk("reset_cpu_gnt", cpu_gnt, 0);
        chk("reset_cnt", conflict_cnt, 0);
        rst = 1'b0;
        tick();

        // load 0xDEADBEEF at 0x010 through the dbg port
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h010; dbg_wdata = 32'hDEADBEEF; dbg_be = 4'hF;
        tick();
        chk("preload_dbg_gnt", dbg_gnt, 1);
        tick();
        dbg_req = 0; dbg_we = 0;
        tick();

        // single CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010; cpu_be = 4'hF;
        tick();
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_addr", mem_addr, 12'h010);
        chk("rd_dbg_gnt", dbg_gnt, 0);
        tick();
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_dbg_rvalid", dbg_rvalid, 0);
        cpu_req = 0;
        tick();

        // simultaneous requests right after reset
        rst = 1;
        tick();
        rst = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h020;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int t = 0; t < 6 && !got; t++) begin
                tick();
                if (cpu_gnt || dbg_gnt) got = 1;
            end
            if (!got) begin
                n_cmp++; n_err++;
                $display("FAIL tie_gnt_timeout: no grant for access %0d", k);
            end
            chk("tie_order_dbg", dbg_gnt, k % 2);
        end
        tick();
        chk("tie_conflict_cnt", conflict_cnt, 8);
        dbg_req = 0;
        drain();

        // debug lock excludes the CPU
        dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("lock_no_cpu_gnt", cpu_gnt, 0);
        end
        dbg_lock = 0;
        tick();
        chk("unlock_cpu_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 0;
        tick();

        // dbg partial write, then CPU read back
        dbg_req = 1; dbg_we = 1; dbg_addr = 12'h3FF; dbg_wdata = 32'h12345678; dbg_be = 4'b0011;
        tick();
        chk("wr_dbg_gnt", dbg_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_be", mem_be, 4'b0011);
        tick();
        chk("wr_no_dbg_rvalid", dbg_rvalid, 0);
        dbg_req = 0; dbg_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h3FF;
        tick();
        chk("rb_cpu_gnt", cpu_gnt, 1);
        tick();
        chk("rb_cpu_rvalid", cpu_rvalid, 1);
        chk("rb_cpu_rdata", cpu_rdata, 32'h00005678);
        cpu_req = 0;
        tick();

        // reset in the middle of an ACCESS cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        tick();
        chk("mid_cpu_gnt", cpu_gnt, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_cpu_gnt", cpu_gnt, 0);
        chk("mid_rst_cpu_rvalid", cpu_rvalid, 0);
        cpu_req = 0;
        tick();
        rst = 0;
        chk("post_rst_cnt", conflict_cnt, 0);
        cpu_req = 1; dbg_req = 1; dbg_we = 0; dbg_addr = 12'h020;
        tick();
        chk("post_rst_cpu_wins", cpu_gnt, 1);
        chk("post_rst_dbg_loses", dbg_gnt, 0);

        // saturation of the 4-bit counter under continuous contention
        for (int t = 0; t < 40; t++) tick();
        chk("sat_cnt_15", s_cnt, 4'd15);
        drain();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            pc = cpu_gnt; pd = dbg_gnt;
            tick();
            if (!cpu_req || pc) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = $urandom_range(0, 1);
                cpu_addr  = AW'($urandom_range(0, 31));
                cpu_wdata = $urandom;
                cpu_be    = BW'($urandom_range(0, 15));
            end
            if (!dbg_req || pd) begin
                dbg_req   = ($urandom_range(0, 2) != 0);
                dbg_we    = $urandom_range(0, 1);
                dbg_addr  = AW'($urandom_range(0, 31));
                dbg_wdata = $urandom;
                dbg_be    = BW'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 7) == 0) dbg_lock = ~dbg_lock;
        end
        dbg_lock = 0;
        drain();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
